// File: rtl/d_counter_backward.sv
// Synchronous down counter built from per-bit D registers with a borrow chain,
// parallel load, wrap/stop mode, terminal-count flags and a registered borrow pulse.
module d_counter_backward #(
  parameter int               WIDTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}},
  parameter bit               WRAP      = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             borrow,
  output logic             done
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH:0]   lowz;
  logic             borrow_q, borrow_d;
  logic             done_q, done_d;
  logic             at_one;

  // lowz[i] is high when every bit below i is zero; the top tap is the zero flag.
  assign lowz[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign lowz[i+1] = lowz[i] & ~q_q[i];
    assign cnt_d[i]  = q_q[i] ^ (en & lowz[i]);

    always_ff @(posedge clk) begin
      q_q[i] <= q_d[i];
    end
  end

  assign zero   = lowz[WIDTH];
  assign at_one = (q_q == WIDTH'(1));

  always_comb begin
    q_d      = q_q;
    borrow_d = 1'b0;
    done_d   = done_q;
    if (reset) begin
      q_d    = RESET_VAL;
      done_d = 1'b0;
    end else if (load) begin
      q_d    = load_val;
      done_d = 1'b0;
    end else if (en) begin
      if (WRAP) begin
        // Counting through zero flips every bit, which is the wrap to all-ones.
        q_d      = cnt_d;
        borrow_d = zero;
      end else if (!zero) begin
        q_d = cnt_d;
        if (at_one) done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    borrow_q <= borrow_d;
    done_q   <= done_d;
  end

  assign q      = q_q;
  assign borrow = borrow_q;
  assign done   = done_q;

endmodule

// File: tb/tb_d_counter_backward.sv
// Bench for d_counter_backward: three configurations share stimulus and are
// compared against a plain-arithmetic countdown model.
module tb_d_counter_backward;

  logic       clk = 1'b0;
  logic       reset = 1'b1, en = 1'b0, load = 1'b0;
  logic [3:0] lv = 4'd0;

  logic [2:0] wq, sq;
  logic [3:0] xq;
  logic       wz, wb, wd, sz, sb, sd, xz, xb, xd;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state per configuration: 0 = W3 wrap, 1 = W3 stop, 2 = W4 wrap reset 0
  int mq[3], mb[3], md[3];
  int cw[3] = '{3, 3, 4};
  int cr[3] = '{1, 0, 1};
  int cv[3] = '{7, 7, 0};

  always #5 clk = ~clk;

  d_counter_backward #(.WIDTH(3), .RESET_VAL(3'd7), .WRAP(1'b1)) u_w (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(lv[2:0]),
    .q(wq), .zero(wz), .borrow(wb), .done(wd));

  d_counter_backward #(.WIDTH(3), .RESET_VAL(3'd7), .WRAP(1'b0)) u_s (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(lv[2:0]),
    .q(sq), .zero(sz), .borrow(sb), .done(sd));

  d_counter_backward #(.WIDTH(4), .RESET_VAL(4'd0), .WRAP(1'b1)) u_x (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(lv),
    .q(xq), .zero(xz), .borrow(xb), .done(xd));

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      int modv;
      modv = 1 << cw[k];
      if (reset) begin
        mq[k] = cv[k]; mb[k] = 0; md[k] = 0;
      end else if (load) begin
        mq[k] = int'(lv) % modv; mb[k] = 0; md[k] = 0;
      end else if (en) begin
        if (mq[k] == 0) begin
          if (cr[k] == 1) begin mq[k] = modv - 1; mb[k] = 1; end
          else mb[k] = 0;
        end else begin
          mq[k] = mq[k] - 1; mb[k] = 0;
          if (cr[k] == 0 && mq[k] == 0) md[k] = 1;
        end
      end else begin
        mb[k] = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; load = 1'b0;
    tick(); tick();
    reset = 1'b0;
    n_tests++; if (wq !== 3'd7) begin n_fail++; $display("FAIL reset_q: got %0d expected 7", wq); end
    n_tests++; if (wz !== 1'b0) begin n_fail++; $display("FAIL reset_zero: got %0b expected 0", wz); end
    n_tests++; if (wb !== 1'b0) begin n_fail++; $display("FAIL reset_borrow: got %0b expected 0", wb); end
    n_tests++; if (sd !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", sd); end
    n_tests++; if (xq !== 4'd0 || xz !== 1'b1) begin n_fail++; $display("FAIL reset_w4: got q=%0d z=%0b expected q=0 z=1", xq, xz); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (wq !== 3'd7) begin n_fail++; $display("FAIL reset_hold: got %0d expected 7", wq); end
    end
  endtask

  task automatic test_wrap();
    int exp_q[9];
    exp_q = '{6, 5, 4, 3, 2, 1, 0, 7, 6};
    en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      n_tests++; if (wq !== 3'(exp_q[i])) begin n_fail++; $display("FAIL wrap_q[%0d]: got %0d expected %0d", i, wq, exp_q[i]); end
      n_tests++; if (wz !== (exp_q[i] == 0)) begin n_fail++; $display("FAIL wrap_zero[%0d]: got %0b expected %0b", i, wz, exp_q[i] == 0); end
      n_tests++; if (wb !== (i == 7)) begin n_fail++; $display("FAIL wrap_borrow[%0d]: got %0b expected %0b", i, wb, i == 7); end
    end
    n_tests++; if (sq !== 3'd0 || sd !== 1'b1) begin n_fail++; $display("FAIL wrap_stopcfg: got q=%0d done=%0b expected q=0 done=1", sq, sd); end
    en = 1'b0;
  endtask

  task automatic test_load_priority();
    en = 1'b1;
    tick(); tick();
    n_tests++; if (wq !== 3'd4) begin n_fail++; $display("FAIL lp_setup: got %0d expected 4", wq); end
    load = 1'b1; lv = 4'd2;
    tick();
    n_tests++; if (wq !== 3'd2) begin n_fail++; $display("FAIL lp_load: got %0d expected 2", wq); end
    load = 1'b0;
    tick();
    n_tests++; if (wq !== 3'd1) begin n_fail++; $display("FAIL lp_count: got %0d expected 1", wq); end
    en = 1'b0;
  endtask

  task automatic test_hold_reset();
    load = 1'b1; lv = 4'd3;
    tick();
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (wq !== 3'd3) begin n_fail++; $display("FAIL hold_q[%0d]: got %0d expected 3", i, wq); end
    end
    load = 1'b1; lv = 4'd0;
    tick();
    load = 1'b0;
    n_tests++; if (wq !== 3'd0 || wz !== 1'b1) begin n_fail++; $display("FAIL hr_at0: got q=%0d z=%0b expected q=0 z=1", wq, wz); end
    reset = 1'b1; en = 1'b1;
    tick();
    reset = 1'b0; en = 1'b0;
    n_tests++; if (wq !== 3'd7) begin n_fail++; $display("FAIL hr_q: got %0d expected 7", wq); end
    n_tests++; if (wb !== 1'b0) begin n_fail++; $display("FAIL hr_borrow: got %0b expected 0", wb); end
  endtask

  task automatic test_stop();
    int exp_q[4];
    exp_q = '{1, 0, 0, 0};
    load = 1'b1; lv = 4'd2;
    tick();
    load = 1'b0; en = 1'b1;
    n_tests++; if (sq !== 3'd2 || sd !== 1'b0) begin n_fail++; $display("FAIL stop_load: got q=%0d done=%0b expected q=2 done=0", sq, sd); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++; if (sq !== 3'(exp_q[i])) begin n_fail++; $display("FAIL stop_q[%0d]: got %0d expected %0d", i, sq, exp_q[i]); end
      n_tests++; if (sd !== (i >= 1)) begin n_fail++; $display("FAIL stop_done[%0d]: got %0b expected %0b", i, sd, i >= 1); end
      n_tests++; if (sb !== 1'b0) begin n_fail++; $display("FAIL stop_borrow[%0d]: got %0b expected 0", i, sb); end
    end
    load = 1'b1; lv = 4'd5;
    tick();
    n_tests++; if (sq !== 3'd5 || sd !== 1'b0) begin n_fail++; $display("FAIL stop_reload: got q=%0d done=%0b expected q=5 done=0", sq, sd); end
    lv = 4'd0;
    tick();
    load = 1'b0;
    tick(); tick();
    n_tests++; if (sq !== 3'd0 || sd !== 1'b0) begin n_fail++; $display("FAIL stop_load0: got q=%0d done=%0b expected q=0 done=0", sq, sd); end
    en = 1'b0;
  endtask

  task automatic test_width();
    reset = 1'b1; en = 1'b0; load = 1'b0;
    tick();
    reset = 1'b0; en = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      n_tests++; if (xq !== 4'((16 - i) & 15)) begin n_fail++; $display("FAIL w4_q[%0d]: got %0d expected %0d", i, xq, (16 - i) & 15); end
      n_tests++; if (xb !== (i == 1 || i == 17)) begin n_fail++; $display("FAIL w4_borrow[%0d]: got %0b expected %0b", i, xb, i == 1 || i == 17); end
    end
    en = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] aq[3];
    logic       az[3], ab[3], ad[3];
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      load  = ($urandom_range(0, 9) == 0);
      en    = ($urandom_range(0, 3) != 0);
      lv    = 4'($urandom_range(0, 15));
      tick();
      aq = '{{1'b0, wq}, {1'b0, sq}, xq};
      az = '{wz, sz, xz};
      ab = '{wb, sb, xb};
      ad = '{wd, sd, xd};
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (aq[k] !== 4'(mq[k]) || az[k] !== (mq[k] == 0) || ab[k] !== 1'(mb[k]) || ad[k] !== 1'(md[k])) begin
          n_fail++;
          $display("FAIL rand[%0d] cfg%0d: got q=%0d z=%0b b=%0b d=%0b expected q=%0d z=%0b b=%0d d=%0d",
                   i, k, aq[k], az[k], ab[k], ad[k], mq[k], mq[k] == 0, mb[k], md[k]);
        end
      end
    end
    reset = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_load_priority();
    test_hold_reset();
    test_stop();
    test_width();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/d_counter_backward.md
Name: d_counter_backward

Overview:
- Synchronous down counter built from D flip-flops; the count-down counterpart of the team's forward D counter.
- Bit i toggles when en=1 and all lower bits q[i-1:0] are zero; this is the borrow chain.
- Adds parallel load, count enable, a wrap/stop mode, terminal-count flags and a registered borrow pulse.
- Serves as a reloadable countdown/timeout source for sequencers in the same design.

Parameters:
- WIDTH, 3, counter width in bits; legal range 2..16.
- RESET_VAL, {WIDTH{1'b1}}, value loaded into q on reset; default is all-ones, so 7 for WIDTH=3.
- WRAP, 1:
  - 1 = wrap from 0 to all-ones.
  - 0 = stop and hold at 0.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- en  input  1  count enable; decrement by 1 per clk edge while high.
- load  input  1  synchronous parallel load request.
- load_val  input  WIDTH  value written to q when load=1.
- q  output  WIDTH  registered count value.
- zero  output  1  combinational flag, (q == 0).
- borrow  output  1  registered one-cycle pulse, high in the cycle q shows all-ones as a result of a 0 -> max wrap.
- done  output  1  registered sticky flag; WRAP=0 only; set when the counter reaches 0 by counting.

Behaviour:
- Reset values: q=RESET_VAL, borrow=0, done=0; zero follows q.
- Priority at each rising clk edge: reset > load > en > hold.
- reset=1: all registers take their reset values, whatever load and en are doing.
- load=1:
  - q <= load_val; borrow <= 0; done <= 0.
  - If load_val==0 and WRAP=0, done stays 0; done is only set by counting into 0.
  - load overrides en in the same cycle; no decrement happens that cycle.
- en=1, load=0, q!=0: q <= q-1, modulo 2^WIDTH; borrow <= 0.
  - If WRAP=0 and q==1, done <= 1 on the same edge that q becomes 0.
- en=1, load=0, q==0:
  - WRAP=1: q <= all-ones; borrow <= 1 for exactly one cycle.
  - WRAP=0: q holds 0; borrow stays 0; done stays 1 (or stays 0 if 0 was reached by load).
- en=0, load=0: q and done hold; borrow <= 0.
- Latency:
  - One clock from en/load to q.
  - borrow is aligned with the wrapped q value, not with the 0 state.
  - zero has zero latency relative to q.
- Continuous en with WRAP=1: q sequence is RESET_VAL, RESET_VAL-1, ..., 0, max, max-1, ...
  - borrow is high once every 2^WIDTH cycles.
- Reset mid-count: takes effect on the next edge; any pending borrow pulse is cleared.
- Structure:
  - One d_flip_flop-style register per bit.
  - Next-state logic per bit: d[i] = q[i] XOR (en AND all lower bits zero), then muxed with load_val, RESET_VAL and the WRAP hold condition.
  - The existing flip-flop's asynchronous reset is not reused; this block's reset is synchronous and drives the D-input mux.
- No X on any output after the first reset edge.
- Inputs are not registered; they must be stable around clk rising edges.

Test Plan:
- Reset: reset=1 for 2 edges, then en=0 -> q=7, zero=0, borrow=0, done=0; q holds 7 for 3 edges.
- Full wrap (WRAP=1): en=1 for 9 edges after reset -> q = 6,5,4,3,2,1,0,7,6; zero high only while q=0; borrow high only in the cycle q=7 after the wrap.
- Load priority: at q=4, drive load=1, load_val=2, en=1 together -> next q=2 (no decrement); next edge with en=1 only -> q=1.
- Stop mode (WRAP=0, WIDTH=3):
  - load 2, then en=1 for 4 edges -> q = 1,0,0,0.
  - done rises on the edge q becomes 0 and stays high; borrow never asserts.
  - load 5 -> done=0, q=5.
- Hold and mid-run reset: at q=3 set en=0 for 3 edges -> q stays 3. Then at q=0 (WRAP=1) assert reset and en together -> q=7 and borrow=0 on that edge (no wrap pulse).
- Width sweep: WIDTH=4, RESET_VAL=0, WRAP=1, en=1 -> first edge q=15 with borrow=1; after 16 edges q=15 again with a second borrow pulse.
